// File: rtl/ps2_scan_sequencer.sv
// PS/2 keyboard receiver: pin synchronisation, frame capture with parity,
// stop-bit and timeout checks, E0/F0 prefix folding, and a show-ahead
// event FIFO read by the CPU through a valid/ready handshake.
module ps2_scan_sequencer #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          event_valid,
    input  logic                          event_ready,
    output logic [7:0]                    event_code,
    output logic                          event_ext,
    output logic                          event_break,
    output logic                          frame_error,
    output logic                          overflow,
    input  logic                          error_clear,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        ST_IDLE,
        ST_RECV
    } state_t;

    // Synchronizers and edge detector
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   clk_s, data_s, fall;

    // Frame receiver
    state_t                 state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [8:0]             shift_q, shift_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [7:0]             byte_q, byte_d;
    logic                   byte_vld_q, byte_vld_d;
    logic                   frame_err_set;

    // Prefix decoder
    logic                   ext_pend_q, ext_pend_d;
    logic                   brk_pend_q, brk_pend_d;
    logic                   push;
    logic [9:0]             push_word;

    // Event FIFO and sticky flags
    logic [9:0]             mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   frame_error_q, frame_error_d;
    logic                   overflow_q, overflow_d;
    logic                   pop, full, wr_en, ovf_set;
    logic [9:0]             head;

    // Shift the pins through the synchronizer chain; edge detect on the last stage.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_s       = clk_sync_q[SYNC_STAGES-1];
        data_s      = data_sync_q[SYNC_STAGES-1];
        clk_prev_d  = clk_s;
        fall        = clk_prev_q & ~clk_s;
    end

    // Frame FSM: start bit, 8 data bits LSB first, odd parity, stop bit, with timeout.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        tmo_d         = tmo_q;
        byte_d        = byte_q;
        byte_vld_d    = 1'b0;
        frame_err_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (fall && !data_s) begin
                    state_d   = ST_RECV;
                    bit_cnt_d = 4'd0;
                end
            end
            ST_RECV: begin
                if (fall) begin
                    tmo_d = '0;
                    if (bit_cnt_q == 4'd9) begin
                        // Stop-bit edge: shift_q holds data[7:0] and parity in bit 8.
                        state_d = ST_IDLE;
                        if ((^shift_q) && data_s) begin
                            byte_vld_d = 1'b1;
                            byte_d     = shift_q[7:0];
                        end else begin
                            frame_err_set = 1'b1;
                        end
                    end else begin
                        shift_d   = {data_s, shift_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = ST_IDLE;
                    tmo_d         = '0;
                    frame_err_set = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Fold E0/F0 prefixes into flags; any other byte becomes an event.
    always_comb begin
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        push       = 1'b0;
        push_word  = {ext_pend_q, brk_pend_q, byte_q};
        if (byte_vld_q) begin
            case (byte_q)
                8'hE0:   ext_pend_d = 1'b1;
                8'hF0:   brk_pend_d = 1'b1;
                default: begin
                    push       = 1'b1;
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end
            endcase
        end
        if (frame_err_set) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end
    end

    // FIFO pointer/count bookkeeping and sticky error flags (set beats clear).
    always_comb begin
        pop      = event_valid & event_ready;
        full     = (count_q == CW'(FIFO_DEPTH));
        wr_en    = push & (~full | pop);
        ovf_set  = push & full & ~pop;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
        if (wr_en && !pop)      count_d = count_q + CW'(1);
        else if (!wr_en && pop) count_d = count_q - CW'(1);
        frame_error_d = frame_err_set | (frame_error_q & ~error_clear);
        overflow_d    = ovf_set       | (overflow_q    & ~error_clear);
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q    <= '1;
            data_sync_q   <= '1;
            clk_prev_q    <= 1'b1;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            tmo_q         <= '0;
            byte_vld_q    <= 1'b0;
            ext_pend_q    <= 1'b0;
            brk_pend_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            frame_error_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            clk_sync_q    <= clk_sync_d;
            data_sync_q   <= data_sync_d;
            clk_prev_q    <= clk_prev_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            tmo_q         <= tmo_d;
            byte_vld_q    <= byte_vld_d;
            ext_pend_q    <= ext_pend_d;
            brk_pend_q    <= brk_pend_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            frame_error_q <= frame_error_d;
            overflow_q    <= overflow_d;
        end
    end

    // Datapath registers: shift register, received byte and FIFO storage.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        byte_q  <= byte_d;
        if (wr_en) mem[wr_ptr_q] <= push_word;
    end

    // Show-ahead outputs; event fields read as zero while the FIFO is empty.
    always_comb begin
        head        = mem[rd_ptr_q];
        event_valid = (count_q != '0);
        event_code  = event_valid ? head[7:0] : 8'h00;
        event_break = event_valid & head[8];
        event_ext   = event_valid & head[9];
        frame_error = frame_error_q;
        overflow    = overflow_q;
        fifo_count  = count_q;
    end

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed bench for ps2_scan_sequencer: bit-banged PS/2 frames with
// hand-computed expected events, flags and FIFO occupancy.
module tb_ps2_scan_sequencer;

    localparam int DEPTH = 8;
    localparam int TO    = 200;
    localparam int HALF  = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk, ps2_data;
    logic       event_valid, event_ready;
    logic [7:0] event_code;
    logic       event_ext, event_break;
    logic       frame_error, overflow, error_clear;
    logic [3:0] fifo_count;

    int checks = 0;
    int errors = 0;

    ps2_scan_sequencer #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES   (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .event_valid(event_valid),
        .event_ready(event_ready),
        .event_code (event_code),
        .event_ext  (event_ext),
        .event_break(event_break),
        .frame_error(frame_error),
        .overflow   (overflow),
        .error_clear(error_clear),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame word: bit0 start, bits1-8 data LSB first, bit9 parity, bit10 stop.
    function automatic logic [10:0] mkframe(input logic [7:0] b, input logic badpar);
        logic par;
        par = ~(^b) ^ badpar;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic send_bit(input logic b);
        cycles(1);
        ps2_data = b;
        cycles(HALF);
        ps2_clk = 1'b0;
        cycles(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) send_bit(bits[i]);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic badpar);
        send_bits(mkframe(b, badpar), 11);
        cycles(2 * HALF);
    endtask

    task automatic pop_one();
        event_ready = 1'b1;
        cycles(1);
        event_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        error_clear = 1'b1;
        cycles(1);
        error_clear = 1'b0;
    endtask

    initial begin
        logic [10:0] fr;
        logic [10:0] rest;
        int          lat;

        reset       = 1'b1;
        ps2_clk     = 1'b1;
        ps2_data    = 1'b1;
        event_ready = 1'b0;
        error_clear = 1'b0;
        #1;
        check("rst_valid", event_valid, 0);
        check("rst_code", event_code, 0);
        check("rst_ferr", frame_error, 0);
        check("rst_ovf", overflow, 0);
        check("rst_count", fifo_count, 0);
        cycles(3);
        reset = 1'b0;
        cycles(5);

        // Single 0x75 frame with latency measured from the stop-bit falling edge.
        fr = mkframe(8'h75, 1'b0);
        check("frame75_parity", fr[9], 0);
        send_bits(fr, 10);
        cycles(1);
        ps2_data = 1'b1;
        cycles(HALF);
        ps2_clk = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            cycles(1);
            if (event_valid && lat == 0) lat = i;
        end
        check("latency_window", (lat >= 4 && lat <= 5), 1);
        cycles(HALF);
        ps2_clk = 1'b1;
        cycles(HALF);
        check("t1_code", event_code, 8'h75);
        check("t1_ext", event_ext, 0);
        check("t1_brk", event_break, 0);
        check("t1_count", fifo_count, 1);
        cycles(3);
        check("t1_stable", event_code, 8'h75);
        pop_one();
        check("t1_popped", event_valid, 0);
        check("t1_count0", fifo_count, 0);

        // Break prefix, then extended break.
        send_frame(8'hF0, 1'b0);
        check("brk_prefix_noevt", event_valid, 0);
        send_frame(8'h75, 1'b0);
        check("brk_count", fifo_count, 1);
        check("brk_code", event_code, 8'h75);
        check("brk_brk", event_break, 1);
        check("brk_ext", event_ext, 0);
        pop_one();
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("eb_count", fifo_count, 1);
        check("eb_code", event_code, 8'h75);
        check("eb_ext", event_ext, 1);
        check("eb_brk", event_break, 1);
        pop_one();

        // Bad parity: no event, sticky error, prefix dropped.
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b1);
        check("par_noevt", event_valid, 0);
        check("par_ferr", frame_error, 1);
        pulse_clear();
        check("par_cleared", frame_error, 0);
        send_frame(8'h75, 1'b0);
        check("par_after_code", event_code, 8'h75);
        check("par_after_brk", event_break, 0);
        check("par_after_ferr", frame_error, 0);
        pop_one();

        // Timeout after start bit plus 4 data bits.
        send_bits(mkframe(8'h75, 1'b0), 5);
        cycles(TO + 20);
        check("to_ferr", frame_error, 1);
        check("to_noevt", event_valid, 0);
        pulse_clear();
        send_frame(8'h75, 1'b0);
        check("to_after_valid", event_valid, 1);
        check("to_after_code", event_code, 8'h75);
        check("to_after_ferr", frame_error, 0);
        pop_one();

        // Overflow: DEPTH+1 events with no consumer.
        for (int i = 0; i < DEPTH + 1; i++) send_frame(8'h1C, 1'b0);
        check("ovf_count", fifo_count, DEPTH);
        check("ovf_flag", overflow, 1);
        check("ovf_head", event_code, 8'h1C);
        event_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain_valid%0d", i), event_valid, 1);
            check($sformatf("drain_code%0d", i), event_code, 8'h1C);
            cycles(1);
        end
        event_ready = 1'b0;
        check("drain_empty", event_valid, 0);
        check("drain_count", fifo_count, 0);
        pulse_clear();
        check("ovf_cleared", overflow, 0);

        // Reset mid-frame with an event queued and an error pending.
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b1);
        check("pre_rst_count", fifo_count, 1);
        check("pre_rst_ferr", frame_error, 1);
        fr = mkframe(8'h75, 1'b0);
        send_bits(fr, 5);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", event_valid, 0);
        check("mid_rst_code", event_code, 0);
        check("mid_rst_ferr", frame_error, 0);
        check("mid_rst_count", fifo_count, 0);
        cycles(3);
        reset = 1'b0;
        rest = fr >> 5;
        send_bits(rest, 6);
        cycles(TO + 50);
        check("post_rst_noevt", event_valid, 0);
        check("post_rst_count", fifo_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound on total run time.
    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ps2_scan_sequencer.md
# ps2_scan_sequencer

Receives raw PS/2 keyboard frames on the ps2_clk/ps2_data pins, validates framing and parity, folds the 0xE0 (extended) and 0xF0 (break) prefix bytes into a single key event, and queues events in a small FIFO. The CPU-side consumer reads events through a valid/ready handshake. The block sits between the keyboard pins and the memory-mapped keyboard register.

## Interface
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 50000: clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
- SYNC_STAGES, 2: synchronizer flops on ps2_clk and ps2_data; ≥2.

Ports:
- clk  in  1  system clock; rising edge; ≥50× the PS/2 clock rate.
- reset  in  1  asynchronous, active-high.
- ps2_clk  in  1  keyboard clock pin; asynchronous; idles high.
- ps2_data  in  1  keyboard data pin; asynchronous; idles high.
- event_valid  out  1  FIFO not empty.
- event_ready  in  1  consumer accepts the head event.
- event_code  out  8  head scan code (prefixes removed).
- event_ext  out  1  head event was preceded by 0xE0.
- event_break  out  1  head event was preceded by 0xF0.
- frame_error  out  1  sticky; set on parity, stop-bit or timeout failure.
- overflow  out  1  sticky; set when an event is dropped on a full FIFO.
- error_clear  in  1  clears frame_error and overflow.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current number of entries.

## Operation
- Synchronizer flops reset to 1. A falling edge is detected when the previous synced ps2_clk = 1 and the current synced ps2_clk = 0. The synced ps2_data is sampled in that cycle.
- Frame FSM:
  - IDLE: a falling edge with data = 0 (start bit) goes to RECV with bit_cnt = 0. A falling edge with data = 1 is ignored.
  - RECV: each falling edge shifts in one bit. The 8 data bits arrive LSB first, then the parity bit, then the stop bit. bit_cnt counts 0..9.
  - On the stop-bit edge, the frame is good if the XOR of data and parity = 1 (odd parity) and stop = 1. In either case the FSM returns to IDLE on the same edge.
  - Bad frame: byte discarded, frame_error set, both decoder prefix flags cleared.
  - Timeout: in RECV, the timeout counter clears on every falling edge. When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE, frame_error is set, and the prefix flags are cleared.
- Prefix decoder (runs on good bytes):
  - 0xE0 sets ext_pend.
  - 0xF0 sets brk_pend.
  - Any other byte pushes {ext_pend, brk_pend, byte} into the FIFO, then clears both flags. This includes 0xAA, 0xFA, 0xFE and 0xE1.
  - Prefix flags persist across frames until consumed or cleared.
- FIFO (show-ahead):
  - event_* outputs always show the head entry.
  - Pop when event_valid & event_ready.
  - Push on a full FIFO with no pop: the new event is dropped and overflow is set.
  - Push and pop in the same cycle while full: both happen and the count is unchanged.
  - Push on an empty FIFO: no bypass; the event becomes visible the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- error_clear clears both sticky flags. If a new error occurs in the same cycle, the set wins.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE; bit_cnt, timeout counter and FIFO pointers 0.
  - Prefix flags 0.
  - Reset mid-frame discards the partial frame; the first valid event after reset requires a new start bit.
- Pin to detection: a ps2_clk falling edge at the pin is detected SYNC_STAGES+1 clk cycles later.
- Event latency: stop-bit edge detected in cycle N → byte registered to the decoder in N+1 → FIFO written at the end of N+1 → event_valid = 1 in N+2.
- event_code, event_ext and event_break are stable while event_valid = 1 and event_ready = 0.
- fifo_count updates on the clk edge after the push or pop.

## Test plan
- Frame with data bits LSB-first 1,0,1,0,1,1,1,0, parity 0, stop 1 → event_valid in N+2; event_code = 0x75, ext = 0, break = 0; fifo_count = 1.
- Frames 0xF0 (parity 1) then 0x75 (parity 0) → exactly one event: code = 0x75, break = 1, ext = 0. Then frames 0xE0, 0xF0, 0x75 → code = 0x75, ext = 1, break = 1.
- 0x75 frame with parity bit 1 → no event and frame_error = 1. Then pulse error_clear → frame_error = 0. A following good frame still decodes to 0x75.
- Start bit plus 4 data bits, then idle TIMEOUT_CYCLES → frame_error = 1, FSM in IDLE. The next full 0x75 frame decodes correctly.
- Hold event_ready = 0 and send FIFO_DEPTH+1 frames of 0x1C → fifo_count = FIFO_DEPTH and overflow = 1. Drain with ready = 1 → FIFO_DEPTH events of 0x1C, then event_valid = 0.
- Assert reset for 3 cycles midway through a frame → all outputs 0. The bench's remaining bits of that frame (no new start bit) produce no event.
